// File: rtl/bcd_pkg.sv
// Shared BCD definitions, also used by the character-ROM stage so digit widths agree.
package bcd_pkg;

  localparam int DIGIT_BITS          = 4;
  localparam int NUM_DIGITS          = 3;
  localparam int MAX_VALUE           = 999;
  localparam int DEFAULT_BINARY_BITS = 10;
  localparam int COUNT_BITS          = $clog2(DEFAULT_BINARY_BITS);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Shift-counter width for an arbitrary operand width (never below 1 bit).
  function automatic int count_width(input int bits);
    return (bits > 1) ? $clog2(bits) : 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble nibble correction: digits of 5 or more get +3 before the next shift.
module bcd_digit_adjust
  import bcd_pkg::*;
#(
  parameter int WIDTH = DIGIT_BITS
) (
  input  logic [WIDTH-1:0] digit,
  output logic [WIDTH-1:0] adjusted
);

  assign adjusted = (digit >= WIDTH'(5)) ? digit + WIDTH'(3) : digit;

endmodule

// File: rtl/binary_to_bcd_converter.sv
// Sequential shift-add-3 converter: one shift per operand bit, results held
// until the next conversion completes so the display never sees partial digits.
module binary_to_bcd_converter #(
  parameter int BINARY_BITS = bcd_pkg::DEFAULT_BINARY_BITS,
  parameter int DIGIT_BITS  = bcd_pkg::DIGIT_BITS,
  parameter int MAX_VALUE   = bcd_pkg::MAX_VALUE
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [BINARY_BITS-1:0] value,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [DIGIT_BITS-1:0]  number2,
  output logic [DIGIT_BITS-1:0]  number1,
  output logic [DIGIT_BITS-1:0]  number0
);

  import bcd_pkg::*;

  localparam int BCD_BITS  = NUM_DIGITS * DIGIT_BITS;
  localparam int CNT_W     = count_width(BINARY_BITS);
  // A narrow operand can never exceed MAX_VALUE, so clamp to the input range.
  localparam int SAT_VALUE = (MAX_VALUE < (2 ** BINARY_BITS)) ? MAX_VALUE : (2 ** BINARY_BITS) - 1;

  localparam logic [BINARY_BITS-1:0] SAT_OPERAND = BINARY_BITS'(SAT_VALUE);
  localparam logic [CNT_W-1:0]       LAST_COUNT  = CNT_W'(BINARY_BITS - 1);

  state_t                          state;
  logic [CNT_W-1:0]                count;
  logic [BCD_BITS-1:0]             bcd;
  logic [BINARY_BITS-1:0]          operand;
  logic                            pending_overflow;
  logic [BCD_BITS-1:0]             bcd_adjusted;
  logic [BCD_BITS+BINARY_BITS-1:0] shifted;
  logic                            value_over;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adjust
      bcd_digit_adjust #(
        .WIDTH (DIGIT_BITS)
      ) u_adjust (
        .digit    (bcd[gi*DIGIT_BITS +: DIGIT_BITS]),
        .adjusted (bcd_adjusted[gi*DIGIT_BITS +: DIGIT_BITS])
      );
    end
  endgenerate

  assign shifted    = {bcd_adjusted, operand} << 1;
  assign value_over = (value > SAT_OPERAND);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      count            <= '0;
      bcd              <= '0;
      operand          <= '0;
      pending_overflow <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      overflow         <= 1'b0;
      number2          <= '0;
      number1          <= '0;
      number0          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            operand          <= value_over ? SAT_OPERAND : value;
            pending_overflow <= value_over;
            bcd              <= '0;
            count            <= '0;
            busy             <= 1'b1;
            state            <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, operand} <= shifted;
          count          <= count + CNT_W'(1);
          // Final shift: publish the post-shift digits directly, bypassing bcd.
          if (count == LAST_COUNT) begin
            number2  <= shifted[BINARY_BITS + 2*DIGIT_BITS +: DIGIT_BITS];
            number1  <= shifted[BINARY_BITS + DIGIT_BITS   +: DIGIT_BITS];
            number0  <= shifted[BINARY_BITS                +: DIGIT_BITS];
            overflow <= pending_overflow;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// Scoreboard bench: stimulus queues expected digits, a negedge monitor checks each done pulse.
module tb_binary_to_bcd_converter;

  localparam int BB      = 10;
  localparam int LATENCY = BB + 1;

  typedef struct {
    int d2;
    int d1;
    int d0;
    int ovf;
    int due;
  } exp_t;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic [BB-1:0] value;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [3:0]    number2;
  logic [3:0]    number1;
  logic [3:0]    number0;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_run = 0;
  logic [12:0] last_out = '0;

  binary_to_bcd_converter #(
    .BINARY_BITS (BB),
    .DIGIT_BITS  (4),
    .MAX_VALUE   (999)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .number2  (number2),
    .number1  (number1),
    .number0  (number0)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse; also checks hold-stability.
  initial forever begin
    @(negedge clock);
    if (!reset_n) begin
      busy_run = 0;
      last_out = '0;
    end else if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("number2", int'(number2), e.d2);
        check("number1", int'(number1), e.d1);
        check("number0", int'(number0), e.d0);
        check("overflow", int'(overflow), e.ovf);
        check("done_latency", cyc, e.due);
        check("busy_cycles", busy_run, BB);
        $display("conv done: digits %0d%0d%0d ovf %0d at cycle %0d", number2, number1, number0, overflow, cyc);
      end
      busy_run = 0;
      last_out = {number2, number1, number0, overflow};
    end else begin
      check("hold_stable", int'({number2, number1, number0, overflow}), int'(last_out));
      if (busy) busy_run++;
    end
  end

  // Call at a negedge: drives start for one cycle and queues the expected result.
  task automatic issue(input int v, input int e2, input int e1, input int e0, input int eo);
    exp_t e;
    e.d2  = e2;
    e.d1  = e1;
    e.d0  = e0;
    e.ovf = eo;
    e.due = cyc + LATENCY;
    sb.push_back(e);
    start = 1'b1;
    value = BB'(v);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 4 * LATENCY; k++) begin
      @(negedge clock);
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic run(input int v, input int e2, input int e1, input int e0, input int eo);
    issue(v, e2, e1, e0, eo);
    wait_idle();
  endtask

  initial begin
    int sat;
    bit seen;
    start   = 1'b0;
    value   = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_digits", int'({number2, number1, number0}), 0);
    reset_n = 1'b1;
    @(negedge clock);

    run(375, 3, 7, 5, 0);

    // Back-to-back: second start lands in the done cycle of the first.
    issue(0, 0, 0, 0, 0);
    seen = 1'b0;
    for (int k = 0; k < 4 * LATENCY; k++) begin
      @(negedge clock);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("b2b_first_done_seen", int'(seen), 1);
    issue(999, 9, 9, 9, 0);
    wait_idle();

    run(1023, 9, 9, 9, 1);
    run(42, 0, 4, 2, 0);

    // Start re-pulsed while busy must be ignored.
    issue(512, 5, 1, 2, 0);
    repeat (3) @(negedge clock);
    start = 1'b1;
    value = BB'(7);
    @(negedge clock);
    start = 1'b0;
    value = '0;
    wait_idle();
    repeat (15) @(negedge clock);

    // Reset mid-conversion aborts with no done.
    issue(876, 8, 7, 6, 0);
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    #1;
    sb.delete();
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_overflow", int'(overflow), 0);
    check("abort_digits", int'({number2, number1, number0}), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("abort_no_done", int'(done), 0);
    run(100, 1, 0, 0, 0);

    for (int v = 0; v < 1024; v++) begin
      sat = (v > 999) ? 999 : v;
      run(v, sat / 100, (sat / 10) % 10, sat % 10, (v > 999) ? 1 : 0);
    end

    repeat (20) @(negedge clock);
    check("queue_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
